// File: rtl/ship_pkg.sv
// Shared types and sprite geometry for the player-ship controller.
// Optional feature macro used by ship_ctrl: SHIP_INERTIA_EN.
package ship_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_EXPLODE = 2'd1,
        ST_RESPAWN = 2'd2
    } ship_state_e;

    // Unscaled sprite side in pixels; local coordinates run 0..31.
    localparam int SPRITE_SIDE = 32;

    // Hull rectangles, inclusive bounds in local sprite coordinates.
    localparam int BODY_X0    = 4;
    localparam int BODY_X1    = 24;
    localparam int BODY_Y0    = 12;
    localparam int BODY_Y1    = 20;
    localparam int NOSE_X0    = 25;
    localparam int NOSE_X1    = 30;
    localparam int NOSE_Y0    = 14;
    localparam int NOSE_Y1    = 18;
    localparam int COCK_X0    = 12;
    localparam int COCK_X1    = 20;
    localparam int COCK_Y0    = 13;
    localparam int COCK_Y1    = 19;
    localparam int UWING_X0   = 2;
    localparam int UWING_X1   = 10;
    localparam int UWING_Y0   = 4;
    localparam int UWING_Y1   = 12;
    localparam int LWING_X0   = 2;
    localparam int LWING_X1   = 10;
    localparam int LWING_Y0   = 20;
    localparam int LWING_Y1   = 28;
    localparam int TAIL_X0    = 0;
    localparam int TAIL_X1    = 4;
    localparam int TAIL_Y0    = 8;
    localparam int TAIL_Y1    = 24;

    // True when (lx, ly) lies inside the inclusive rectangle [x0..x1] x [y0..y1].
    function automatic logic in_rect(input logic [4:0] lx, input logic [4:0] ly,
                                     input int x0, input int x1,
                                     input int y0, input int y1);
        return (int'(lx) >= x0) && (int'(lx) <= x1) &&
               (int'(ly) >= y0) && (int'(ly) <= y1);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: synchronises an asynchronous v_sync into the clk
// domain and emits a registered one-cycle pulse on each rising edge.
// The pulse appears 3 clk after the v_sync rise (2 sync flops + output flop).
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic v_sync,
    output logic tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic tick_q,  tick_d;

    // Next-state: shift the synchroniser chain and detect the rising edge.
    always_comb begin
        sync1_d = v_sync;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        tick_d  = sync2_q & ~prev_q;
    end

    // Synchroniser, edge history and registered tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ship_ctrl.sv
// Player-ship controller and sprite renderer. Runs on the pixel clock,
// updates motion and the alive/explode/respawn FSM once per frame tick,
// and renders the hull combinationally from the current pixel position.
// Optional feature macro: SHIP_INERTIA_EN (defined: velocity ramps by ACCEL
// per frame; undefined: velocity jumps straight to +/-MAX_SPD or 0).
module ship_ctrl
    import ship_pkg::*;
#(
    parameter int SHIP_X         = 40,
    parameter int SCALE_SHIFT    = 0,
    parameter int Y_MIN          = 15,
    parameter int Y_MAX          = 435,
    parameter int Y_RESET        = 240,
    parameter int MAX_SPD        = 8,
    parameter int ACCEL          = 1,
    parameter int EXPLODE_FRAMES = 30,
    parameter int INVULN_FRAMES  = 120,
    parameter int BLINK_SHIFT    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_sync,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       hit,
    output logic [9:0] ship_y_out,
    output logic       ship_on,
    output logic [1:0] ship_state,
    output logic       vulnerable
);

    localparam int CNT_W = 16;
    localparam int BOX   = SPRITE_SIDE << SCALE_SHIFT;

    // Per-tick velocity step. Without inertia any step at least as large as
    // the full -MAX..+MAX swing lands on the target in a single tick.
`ifdef SHIP_INERTIA_EN
    localparam int RAMP = ACCEL;
`else
    localparam int RAMP = (ACCEL > 2 * MAX_SPD) ? ACCEL : 2 * MAX_SPD;
`endif

    localparam logic signed [10:0] MAX_V   = 11'(MAX_SPD);
    localparam logic signed [10:0] RAMP_V  = 11'(RAMP);
    localparam logic signed [10:0] Y_MIN_V = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_V = 11'(Y_MAX);

    // Move cur toward tgt by at most RAMP_V without overshooting it.
    function automatic logic signed [10:0] approach(input logic signed [10:0] cur,
                                                    input logic signed [10:0] tgt);
        if (cur < tgt)
            return ((tgt - cur) > RAMP_V) ? (cur + RAMP_V) : tgt;
        else if (cur > tgt)
            return ((cur - tgt) > RAMP_V) ? (cur - RAMP_V) : tgt;
        else
            return cur;
    endfunction

    // Saturate a candidate top-edge y into [Y_MIN, Y_MAX].
    function automatic logic signed [10:0] clamp_y(input logic signed [10:0] y);
        if (y < Y_MIN_V)
            return Y_MIN_V;
        else if (y > Y_MAX_V)
            return Y_MAX_V;
        else
            return y;
    endfunction

    logic                     tick;
    ship_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [10:0]       vel_q, vel_d;
    logic [9:0]               ship_y_q, ship_y_d;
    logic                     hit_lat_q, hit_lat_d;
    logic                     vulnerable_q, vulnerable_d;

    logic signed [10:0]       vel_tgt;
    logic signed [10:0]       vel_new;
    logic signed [10:0]       y_n;
    logic signed [10:0]       y_cl;
    logic [9:0]               mv_y;
    logic signed [10:0]       mv_vel;

    logic                     in_x, in_y, in_box;
    logic [9:0]               dx, dy;
    logic [4:0]               lx, ly;
    logic                     hull;
    logic                     on_c;

    frame_tick_gen u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .v_sync (v_sync),
        .tick   (tick)
    );

    // Candidate motion for this tick: new velocity, then clamped position.
    always_comb begin
        vel_tgt = '0;
        if (move_up && !move_down)
            vel_tgt = -MAX_V;
        else if (move_down && !move_up)
            vel_tgt = MAX_V;
        vel_new = approach(vel_q, vel_tgt);
        y_n     = signed'({1'b0, ship_y_q}) + vel_new;
        y_cl    = clamp_y(y_n);
        mv_y    = y_cl[9:0];
        mv_vel  = (y_cl != y_n) ? 11'sd0 : vel_new;
    end

    // Next-state for FSM, counter, motion, hit latch and registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vel_d     = vel_q;
        ship_y_d  = ship_y_q;
        hit_lat_d = (tick ? 1'b0 : hit_lat_q) | (hit & (state_q == ST_ALIVE));
        if (tick) begin
            case (state_q)
                ST_ALIVE: begin
                    if (hit_lat_q) begin
                        state_d = ST_EXPLODE;
                        cnt_d   = CNT_W'(EXPLODE_FRAMES - 1);
                        vel_d   = '0;
                    end else begin
                        ship_y_d = mv_y;
                        vel_d    = mv_vel;
                    end
                end
                ST_EXPLODE: begin
                    if (cnt_q == '0) begin
                        state_d  = ST_RESPAWN;
                        ship_y_d = 10'(Y_RESET);
                        vel_d    = '0;
                        cnt_d    = CNT_W'(INVULN_FRAMES - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_RESPAWN: begin
                    ship_y_d = mv_y;
                    vel_d    = mv_vel;
                    if (cnt_q == '0)
                        state_d = ST_ALIVE;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
        vulnerable_d = (state_d == ST_ALIVE);
    end

    // Ship state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ALIVE;
            cnt_q        <= '0;
            vel_q        <= '0;
            ship_y_q     <= 10'(Y_RESET);
            hit_lat_q    <= 1'b0;
            vulnerable_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vel_q        <= vel_d;
            ship_y_q     <= ship_y_d;
            hit_lat_q    <= hit_lat_d;
            vulnerable_q <= vulnerable_d;
        end
    end

    // Sprite render: box test, scaled local coordinates, hull and state mask.
    always_comb begin
        in_x   = ({1'b0, pix_x} >= 11'(SHIP_X)) && ({1'b0, pix_x} < 11'(SHIP_X + BOX));
        in_y   = ({1'b0, pix_y} >= {1'b0, ship_y_q}) &&
                 ({1'b0, pix_y} < ({1'b0, ship_y_q} + 11'(BOX)));
        in_box = in_x & in_y;
        dx     = pix_x - 10'(SHIP_X);
        dy     = pix_y - ship_y_q;
        lx     = 5'(dx >> SCALE_SHIFT);
        ly     = 5'(dy >> SCALE_SHIFT);
        hull   = in_rect(lx, ly, BODY_X0,  BODY_X1,  BODY_Y0,  BODY_Y1)  |
                 in_rect(lx, ly, NOSE_X0,  NOSE_X1,  NOSE_Y0,  NOSE_Y1)  |
                 in_rect(lx, ly, COCK_X0,  COCK_X1,  COCK_Y0,  COCK_Y1)  |
                 in_rect(lx, ly, UWING_X0, UWING_X1, UWING_Y0, UWING_Y1) |
                 in_rect(lx, ly, LWING_X0, LWING_X1, LWING_Y0, LWING_Y1) |
                 in_rect(lx, ly, TAIL_X0,  TAIL_X1,  TAIL_Y0,  TAIL_Y1);
        case (state_q)
            ST_ALIVE:   on_c = in_box & hull;
            ST_RESPAWN: on_c = in_box & hull & ~cnt_q[BLINK_SHIFT];
            ST_EXPLODE: on_c = in_box & (lx[2] ^ ly[2] ^ cnt_q[1]);
            default:    on_c = 1'b0;
        endcase
    end

    assign ship_on    = on_c;
    assign ship_y_out = ship_y_q;
    assign ship_state = state_q;
    assign vulnerable = vulnerable_q;

endmodule

// File: doc/ship_ctrl.md
Name: ship_ctrl

Overview:
- Parametrised player-ship controller and sprite renderer for the VGA game.
- Runs on the system pixel clock and detects frame starts from v_sync internally, instead of being clocked by v_sync.
- Adds velocity with inertia, vertical clamping, sprite scaling, and a hit → explode → respawn state machine with blinking invulnerability.
- Feeds ship_on to the pixel mux and ship_y_out to collision and projectile logic.

Parameters:
- SHIP_X, 40: left edge of the sprite box, in pixels.
- SCALE_SHIFT, 0: sprite scale factor of 2^SCALE_SHIFT (legal 0..2). Box side is 32<<SCALE_SHIFT.
- Y_MIN, 15: minimum top-edge y.
- Y_MAX, 435: maximum top-edge y.
- Y_RESET, 240: y at reset and at respawn.
- MAX_SPD, 8: maximum speed magnitude, in pixels per frame.
- ACCEL, 1: speed change per frame.
- EXPLODE_FRAMES, 30: length of the explosion animation, in frames.
- INVULN_FRAMES, 120: length of respawn invulnerability, in frames.
- BLINK_SHIFT, 3: blink half-period is 2^BLINK_SHIFT frames.

Ports:
- clk  in  1  system pixel clock
- rst_n  in  1  asynchronous active-low reset
- v_sync  in  1  vertical sync from the VGA timing generator (asynchronous to the logic; synchronised internally)
- pix_x  in  10  current pixel x
- pix_y  in  10  current pixel y
- move_up  in  1  level input
- move_down  in  1  level input
- hit  in  1  single-cycle collision pulse
- ship_y_out  out  10  registered top-edge y
- ship_on  out  1  sprite pixel active
- ship_state  out  2  0=ALIVE, 1=EXPLODE, 2=RESPAWN
- vulnerable  out  1  high only when the ship is ALIVE

Behaviour:
- Reset values: ship_y=Y_RESET, vel=0, state=ALIVE, frame counter=0, hit latch=0, sync flops=0. Outputs at reset: ship_y_out=Y_RESET, ship_state=0, vulnerable=1. ship_on follows the combinational rule below.
- Frame tick: v_sync passes through a 2-flop synchroniser and a rising-edge detect. tick is a 1-cycle pulse 3 clk after the v_sync rise. All position, velocity and state updates happen only on tick.
- Hit latch: set when hit=1 and state==ALIVE. Cleared on the next tick, where it is consumed. Hits in EXPLODE or RESPAWN are ignored.
- Velocity is an 11-bit signed value, updated on tick when state≠EXPLODE:
  - up only: vel = max(vel−ACCEL, −MAX_SPD)
  - down only: vel = min(vel+ACCEL, MAX_SPD)
  - neither or both: vel moves toward 0 by ACCEL without crossing 0
- Position: y_n = ship_y + vel_new, computed in 11-bit signed arithmetic.
  - If y_n < Y_MIN: ship_y=Y_MIN, vel=0.
  - If y_n > Y_MAX: ship_y=Y_MAX, vel=0.
  - Otherwise ship_y=y_n.
- FSM transitions, all evaluated on tick:
  - ALIVE with hit latch set → EXPLODE. cnt=EXPLODE_FRAMES−1, vel=0; position is frozen. This has priority over movement on that tick.
  - EXPLODE with cnt==0 → RESPAWN. ship_y=Y_RESET, vel=0, cnt=INVULN_FRAMES−1. Otherwise cnt−1.
  - RESPAWN with cnt==0 → ALIVE. Otherwise cnt−1. Movement is active in RESPAWN.
- Render (combinational from pix_x, pix_y and registered state, zero latency):
  - in_box when pix_x ∈ [SHIP_X, SHIP_X+box) and pix_y ∈ [ship_y, ship_y+box).
  - Local coordinates: lx=(pix_x−SHIP_X)>>SCALE_SHIFT and ly=(pix_y−ship_y)>>SCALE_SHIFT, both in 0..31.
  - Hull shape (inclusive rectangles): body lx4–24/ly12–20; nose 25–30/14–18; cockpit 12–20/13–19; upper wing 2–10/4–12; lower wing 2–10/20–28; tail 0–4/8–24.
  - ALIVE: ship_on = in_box & hull.
  - RESPAWN: ship_on = in_box & hull & ~cnt[BLINK_SHIFT].
  - EXPLODE: ship_on = in_box & (lx[2]^ly[2]^cnt[1]), a flickering checkerboard.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
- SHIP_INERTIA_EN.
- Defined: the acceleration and deceleration ramps described above.
- Undefined: no inertia. On tick, vel = −MAX_SPD for up only, +MAX_SPD for down only, 0 otherwise. Clamping, the FSM and rendering are unchanged.

Decomposition:
- Package ship_pkg holds:
  - the state enum (ALIVE/EXPLODE/RESPAWN)
  - SPRITE_SIDE=32
  - the hull rectangle bounds as localparams
- One sub-module, frame_tick_gen: synchroniser plus rising-edge detect, outputting tick. It is reusable by enemy and bullet blocks.
- Hull decode stays inline as combinational logic.

Test Plan:
- Reset, then idle for 3 frames → ship_y_out=240, ship_state=0, vulnerable=1, vel stays 0.
- SHIP_INERTIA_EN, move_down held for 10 ticks → y sequence 241, 243, 246, 250, 255, 261, 268, 276, 284, 292 (vel saturates at 8).
- Release after reaching vel=8 → vel decays 7..0 over 8 ticks; y increases by 28 in total, then holds.
- move_up held from y=20 → clamps at y=15, vel=0; further ticks hold y at 15.
- Pulse hit mid-frame in ALIVE → on next tick ship_state=1 and y frozen. After 30 ticks ship_state=2 and y=240. A hit during RESPAWN is ignored. After 120 more ticks ship_state=0.
- SCALE_SHIFT=1, ship_y=240, probe (pix_x=40+2·25, pix_y=240+2·16) → ship_on=1 (nose). Probe (pix_x=40+2·31, pix_y=240) → ship_on=0.
